// File: rtl/instruction_fetch_unit_if.sv
// Purpose: groups the fetch unit's PC, instruction-memory and decode-side
//          handshake signals into one bundle.
// Ports (modports):
//   master - the fetch unit: drives fetch_stall, imem_req_*, if_valid/if_instr/if_pc
//   slave  - the surroundings (PC, memory, decode): drive pc_value, flush,
//            imem_req_ready, imem_resp_*, if_ready
interface instruction_fetch_unit_if;
  logic [31:0] pc_value;
  logic        flush;
  logic        fetch_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    input  pc_value, flush, imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    output fetch_stall, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output pc_value, flush, imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    input  fetch_stall, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Purpose: issues in-order word fetches at the current PC, pairs each returned
//          word with its PC in a small buffer and hands it to decode over a
//          valid/ready handshake. A flush discards buffered and in-flight
//          fetches; responses still in flight are counted and dropped.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low
//   bus   - instruction_fetch_unit_if.master (PC, imem request/response, decode)
//
// state | meaning
// RUN   | no stale responses outstanding
// DRAIN | drop_q > 0; stale responses are being discarded, new fetches still issue
module instruction_fetch_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [AW-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_instr_d [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_pc_d    [FIFO_DEPTH];
  logic [31:0]     pend_pc_q    [FIFO_DEPTH];
  logic [31:0]     pend_pc_d    [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        req_valid, accept, pop, resp_drop, resp_keep, resp_any;

  // Buffered plus outstanding fetches never exceed the buffer size, so a
  // returning word always has a slot.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign req_valid   = reset && !bus.flush && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign accept      = req_valid && bus.imem_req_ready;
  assign pop         = (fifo_cnt_q != '0) && bus.if_ready;
  assign resp_drop   = bus.imem_resp_valid && (drop_q != '0);
  // A response with nothing in flight (e.g. a late one from before a reset) is ignored.
  assign resp_keep   = bus.imem_resp_valid && (drop_q == '0) && (outstanding_q != '0);
  assign resp_any    = resp_drop || resp_keep;

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fifo_cnt_d    = fifo_cnt_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    pend_wr_d     = pend_wr_q;
    pend_rd_d     = pend_rd_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    pend_pc_d     = pend_pc_q;

    if (bus.flush) begin
      // Everything still in flight becomes stale; a response arriving in the
      // flush cycle itself retires one of them.
      fifo_cnt_d    = '0;
      fifo_wr_d     = '0;
      fifo_rd_d     = '0;
      pend_wr_d     = '0;
      pend_rd_d     = '0;
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q - CW'(resp_any);
    end else begin
      if (accept) begin
        pend_pc_d[pend_wr_q] = bus.pc_value;
        pend_wr_d            = pend_wr_q + AW'(1);
      end
      if (resp_keep) begin
        fifo_instr_d[fifo_wr_q] = bus.imem_resp_data;
        fifo_pc_d[fifo_wr_q]    = pend_pc_q[pend_rd_q];
        fifo_wr_d               = fifo_wr_q + AW'(1);
        pend_rd_d               = pend_rd_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end
      fifo_cnt_d    = fifo_cnt_q + CW'(resp_keep) - CW'(pop);
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp_keep);
      drop_d        = drop_q - CW'(resp_drop);
    end

    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_cnt_q    <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pend_wr_q     <= '0;
      pend_rd_q     <= '0;
      fifo_instr_q  <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      pend_pc_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      pend_wr_q     <= pend_wr_d;
      pend_rd_q     <= pend_rd_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign bus.fetch_stall    = !(accept || bus.flush);
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_value;
  assign bus.if_valid       = (fifo_cnt_q != '0);
  assign bus.if_instr       = fifo_instr_q[fifo_rd_q];
  assign bus.if_pc          = fifo_pc_q[fifo_rd_q];

  // A response must belong either to a live fetch or to a stale one.
  a_resp_expected: assert property (@(posedge clock) disable iff (!reset)
    bus.imem_resp_valid |-> (outstanding_q != '0 || drop_q != '0));

  // Back-to-back flushes must not push the stale count past its range.
  a_drop_range: assert property (@(posedge clock) disable iff (!reset)
    bus.flush |-> (({1'b0, drop_q} + {1'b0, outstanding_q}) < (CW+1)'(2**CW)));
endmodule
